inst_encoder: RTL
=================

// Module: inst_encoder
// PURPOSE
//  Inverse of immediate generation: packs decoded fields (opcode, regs, funct, immediate or target) into RV32I words.
//  Used by the boot/self-test program loader to write instruction memory.
//  2-stage valid/ready pipeline. Owns a running write-address counter (PC).
//  B/J targets are absolute; the block subtracts the PC to get the encoded offset.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  PC value after reset
//  ERR_W      8              width of saturating error counter
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      synchronous, active-low reset
//  pc_load    in   1      load PC counter with pc_value
//  pc_value   in   32     new PC; must be word aligned (bits[1:0] ignored, forced 0)
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid & in_ready
//  in_fmt     in   3      fmt_e: R=0 I=1 S=2 B=3 U=4 J=5; 6,7 illegal
//  in_opcode  in   7      inst[6:0]
//  in_rd      in   5      inst[11:7] (R/I/U/J)
//  in_rs1     in   5      inst[19:15] (R/I/S/B)
//  in_rs2     in   5      inst[24:20] (R/S/B)
//  in_funct3  in   3      inst[14:12] (R/I/S/B)
//  in_funct7  in   7      inst[31:25] (R only)
//  in_value   in   32     I/S: signed immediate; U: upper value; B/J: absolute target
//  out_valid  out  1      encoded word valid
//  out_ready  in   1      consumer accepts when out_valid & out_ready
//  out_inst   out  32     encoded instruction
//  out_addr   out  32     PC assigned to this instruction
//  out_err    out  1      encoding error; out_inst is the NOP 32'h0000_0013
//  err_cnt    out  ERR_W  count of errored words emitted; saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): PC<=BASE_ADDR; both stages invalid; out_valid=0, out_inst=0, out_addr=0, out_err=0, err_cnt=0; in_ready=0 during reset.
//  Reset mid-operation drops all in-flight words. No partial output.
//  Stage 1 captures fields on accept, tags them with the current PC, and computes off=in_value-PC (32-bit wrap).
//  Stage 1 also computes range flags. Stage 2 packs the word and drives the registered outputs.
//  Latency: accept at cycle N -> out_valid at N+2 if out_ready is held high. Throughput is 1 word/cycle.
//  in_ready = !s1_valid | (!s2_valid | out_ready). A stage advances only when the next stage is empty or draining.
//  Outputs hold stable while out_valid & !out_ready. No drop, no duplication, order preserved.
//  PC increments by 4 on each accepted request (mod 2^32 wrap).
//  pc_load has priority over increment:
//   - pc_load alone: PC<=pc_value.
//   - pc_load with accept: the accepted request takes out_addr=pc_value and PC<=pc_value+4.
//  Error rules (checked at stage 1):
//   - I, S: in_value must be a sign-extended 12-bit value.
//   - B: off must fit 13-bit signed and off[0]=0.
//   - J: off must fit 21-bit signed and off[0]=0.
//   - U: in_value[11:0] must be 0.
//   - R: never errors.
//   - fmt 6/7: always an error.
//   - On error: word is still emitted, with out_err=1, out_inst=NOP, and the PC slot consumed. err_cnt increments on that output handshake.
//  Packing (imm = in_value for I/S/U, off for B/J):
//   - R: {f7,rs2,rs1,f3,rd,op}
//   - I: {imm[11:0],rs1,f3,rd,op}
//   - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
//   - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
//   - U: {imm[31:12],rd,op}
//   - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//   - Unused fields for a format are ignored.
// STRUCTURE
//  Package rv32i_enc_pkg: fmt_e enum; NOP_INST=32'h0000_0013; range-check functions fits_s12/s13/s21.
//  Sub-module inst_pack (combinational): fmt, fields, imm -> 32-bit word. Instantiated in stage 2.
//  Top holds the PC counter, the two pipeline registers, handshake logic and err_cnt.
// TESTING
//  1 I: pc_load 0; fmt=I op=13 rd=1 rs1=0 f3=0 value=FFFF_FFFF -> out_inst FFF0_0093, out_addr 0, 2 cycles later.
//  2 B: pc_load 100; fmt=B op=63 rs1=1 rs2=2 f3=0 target=0F8 (off=-8) -> FE20_8CE3, out_addr 100.
//  3 J+U: PC=0, fmt=J op=6F rd=1 target=800 -> 0010_00EF at 0; next fmt=U op=37 rd=5 value=1234_5000 -> 1234_52B7 at 4.
//  4 Errors: fmt=I value=800 -> err=1, inst 0000_0013, err_cnt=1; fmt=B odd target -> err_cnt=2; PC still +4 each.
//  5 Backpressure: out_ready=0 for 5 cycles, offer 3 requests -> 2 accepted, in_ready=0, outputs stable; release -> in-order, no dup.
//  6 Reset mid-stream with 2 in flight; fmt=7 illegal; pc_load with accept -> state cleared; err; addr=pc_value, next +4.

Source files
------------

// File: rtl/rv32i_enc_pkg.sv
// Shared types and range helpers for the RV32I instruction encoder.
// Formats 6 and 7 are deliberately left out of fmt_e; they are treated as errors.
package rv32i_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic fits_s12(input logic signed [31:0] v);
        return (v >= -32'sd2048) && (v <= 32'sd2047);
    endfunction

    function automatic logic fits_s13(input logic signed [31:0] v);
        return (v >= -32'sd4096) && (v <= 32'sd4095);
    endfunction

    function automatic logic fits_s21(input logic signed [31:0] v);
        return (v >= -32'sd1048576) && (v <= 32'sd1048575);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle between the program loader and the instruction encoder.
interface inst_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_value;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_value, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_value, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err
    );

endinterface

// File: rtl/inst_pack.sv
// Combinational RV32I word packer: scatters already-validated fields and immediate into the format layout.
module inst_pack
    import rv32i_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst
);

    always_comb begin
        inst = NOP_INST;
        case (fmt)
            FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: inst = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: inst = {imm[31:12], rd, opcode};
            FMT_J: inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: inst = NOP_INST;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder with a running write-address (PC) counter.
// Stage 1 tags the request with its PC and range-checks it; stage 2 packs and holds the output word.
module inst_encoder
    import rv32i_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_load,
    input  logic [31:0]      pc_value,
    inst_encoder_if.slave    bus,
    output logic [ERR_W-1:0] err_cnt
);

    logic [31:0]        pc;
    logic [31:0]        pc_cur;
    logic               acc;
    logic               adv_p2;

    logic signed [31:0] value_p0;
    logic signed [31:0] off_p0;
    logic [31:0]        imm_p0;
    logic               err_p0;

    logic               vld_p1;
    logic [2:0]         fmt_p1;
    logic [6:0]         opcode_p1;
    logic [4:0]         rd_p1;
    logic [4:0]         rs1_p1;
    logic [4:0]         rs2_p1;
    logic [2:0]         funct3_p1;
    logic [6:0]         funct7_p1;
    logic [31:0]        imm_p1;
    logic [31:0]        addr_p1;
    logic               err_p1;
    logic [31:0]        packed_p1;

    logic               vld_p2;
    logic [31:0]        inst_p2;
    logic [31:0]        addr_p2;
    logic               err_p2;

    // pc_load overrides the counter in the same cycle so an accepted request can take the loaded address.
    assign pc_cur = pc_load ? (pc_value & ~32'h0000_0003) : pc;

    assign bus.in_ready = rst_n & (!vld_p1 | !vld_p2 | bus.out_ready);
    assign acc          = bus.in_valid & bus.in_ready;
    assign adv_p2       = vld_p1 & (!vld_p2 | bus.out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= BASE_ADDR;
        end else if (acc) begin
            pc <= pc_cur + 32'd4;
        end else if (pc_load) begin
            pc <= pc_cur;
        end
    end

    // ---- stage 0 -> 1: offset, range check, capture ----
    assign value_p0 = $signed(bus.in_value);
    assign off_p0   = value_p0 - $signed(pc_cur);

    always_comb begin
        imm_p0 = bus.in_value;
        err_p0 = 1'b1;
        case (bus.in_fmt)
            FMT_R: err_p0 = 1'b0;
            FMT_I,
            FMT_S: err_p0 = !fits_s12(value_p0);
            FMT_B: begin
                imm_p0 = off_p0;
                err_p0 = !fits_s13(off_p0) | off_p0[0];
            end
            FMT_U: err_p0 = |bus.in_value[11:0];
            FMT_J: begin
                imm_p0 = off_p0;
                err_p0 = !fits_s21(off_p0) | off_p0[0];
            end
            default: err_p0 = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (acc) begin
            vld_p1 <= 1'b1;
        end else if (adv_p2) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            fmt_p1    <= bus.in_fmt;
            opcode_p1 <= bus.in_opcode;
            rd_p1     <= bus.in_rd;
            rs1_p1    <= bus.in_rs1;
            rs2_p1    <= bus.in_rs2;
            funct3_p1 <= bus.in_funct3;
            funct7_p1 <= bus.in_funct7;
            imm_p1    <= imm_p0;
            addr_p1   <= pc_cur;
            err_p1    <= err_p0;
        end
    end

    // ---- stage 1 -> 2: pack and register outputs ----
    inst_pack u_pack (
        .fmt    (fmt_p1),
        .opcode (opcode_p1),
        .rd     (rd_p1),
        .rs1    (rs1_p1),
        .rs2    (rs2_p1),
        .funct3 (funct3_p1),
        .funct7 (funct7_p1),
        .imm    (imm_p1),
        .inst   (packed_p1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            inst_p2 <= 32'h0;
            addr_p2 <= 32'h0;
            err_p2  <= 1'b0;
        end else if (adv_p2) begin
            vld_p2  <= 1'b1;
            inst_p2 <= err_p1 ? NOP_INST : packed_p1;
            addr_p2 <= addr_p1;
            err_p2  <= err_p1;
        end else if (bus.out_ready) begin
            vld_p2  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (vld_p2 && bus.out_ready && err_p2 && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_inst  = inst_p2;
    assign bus.out_addr  = addr_p2;
    assign bus.out_err   = err_p2;

endmodule
